// File: rtl/mem_request_issuer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_request_issuer: issues one SIMT load/store to the N-core memory       |
// | controller, holds it until MReady returns and captures load results.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_request_issuer #(
  parameter int N_CORES = 4,
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_load,
  input  logic                  start_store,
  input  logic [N_CORES-1:0]    lane_mask,
  input  logic [N_CORES*AW-1:0] lane_addr,
  input  logic [N_CORES*DW-1:0] lane_wdata,
  output logic                  MRead,
  output logic                  MWrite,
  output logic [N_CORES-1:0]    en,
  output logic [N_CORES*AW-1:0] in_addr,
  output logic [N_CORES*DW-1:0] in_data,
  input  logic                  MReady,
  input  logic [N_CORES*DW-1:0] q,
  output logic [N_CORES*DW-1:0] load_data,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_HIGH = 3'd3,
    CAPTURE   = 3'd4,
    FINISH    = 3'd5
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt;
  logic          is_store;
  logic          accept;
  logic          timed_out;
  logic          in_wait;

  assign in_wait = (state == WAIT_LOW) || (state == WAIT_HIGH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    timed_out  = 1'b0;
    case (state)
      IDLE: begin
        if (start_load || start_store) begin
          accept     = 1'b1;
          state_next = (lane_mask == '0) ? FINISH : ISSUE;
        end
      end
      ISSUE: state_next = WAIT_LOW;
      WAIT_LOW: begin
        // MReady never seen low within two cycles: controller finished inside the strobe window
        if (!MReady)                  state_next = WAIT_HIGH;
        else if (wait_cnt == CW'(1))  state_next = CAPTURE;
        else if (wait_cnt == LAST_WAIT) begin
          timed_out  = 1'b1;
          state_next = FINISH;
        end
      end
      WAIT_HIGH: begin
        if (MReady) state_next = CAPTURE;
        else if (wait_cnt == LAST_WAIT) begin
          timed_out  = 1'b1;
          state_next = FINISH;
        end
      end
      CAPTURE: state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MRead       <= 1'b0;
      MWrite      <= 1'b0;
      en          <= '0;
      in_addr     <= '0;
      in_data     <= '0;
      load_data   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
      is_store    <= 1'b0;
    end else begin
      MRead  <= 1'b0;
      MWrite <= 1'b0;
      done   <= 1'b0;

      if (accept) begin
        en          <= lane_mask;
        in_addr     <= lane_addr;
        in_data     <= lane_wdata;
        is_store    <= start_store;
        timeout_err <= 1'b0;
        busy        <= 1'b1;
        if (lane_mask != '0) begin
          MRead  <= ~start_store;
          MWrite <= start_store;
        end
      end

      if (in_wait) wait_cnt <= wait_cnt + 1'b1;
      else         wait_cnt <= '0;

      if (timed_out) timeout_err <= 1'b1;

      if (state == CAPTURE && !is_store) begin
        for (int i = 0; i < N_CORES; i++) begin
          if (en[i]) load_data[i*DW +: DW] <= q[i*DW +: DW];
        end
      end

      if (state == FINISH) begin
        done <= 1'b1;
        en   <= '0;
        busy <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_request_issuer.sv
`default_nettype none
// Directed self-checking bench for mem_request_issuer with a behavioural
// memory-controller model answering the strobes.
module tb_mem_request_issuer;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start_load = 1'b0;
  logic          start_store = 1'b0;
  logic [N-1:0]    lane_mask = '0;
  logic [N*AW-1:0] lane_addr = '0;
  logic [N*DW-1:0] lane_wdata = '0;
  logic          MRead, MWrite, MReady;
  logic [N-1:0]    en;
  logic [N*AW-1:0] in_addr;
  logic [N*DW-1:0] in_data;
  logic [N*DW-1:0] q = '0;
  logic [N*DW-1:0] load_data;
  logic          busy, done, timeout_err;

  mem_request_issuer #(.N_CORES(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .start_load(start_load), .start_store(start_store),
    .lane_mask(lane_mask), .lane_addr(lane_addr), .lane_wdata(lane_wdata),
    .MRead(MRead), .MWrite(MWrite), .en(en), .in_addr(in_addr), .in_data(in_data),
    .MReady(MReady), .q(q), .load_data(load_data),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Controller model: on a strobe, pull MReady low for ctl_k cycles (or ignore it when ctl_ignore)
  int ctl_k = 4;
  bit ctl_ignore = 1'b0;
  int low_left;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      MReady   <= 1'b1;
      low_left <= 0;
    end else if (low_left > 0) begin
      low_left <= low_left - 1;
      if (low_left == 1) MReady <= 1'b1;
    end else if ((MRead || MWrite) && !ctl_ignore) begin
      MReady   <= 1'b0;
      low_left <= ctl_k;
    end
  end

  int rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
  always @(negedge clk) begin
    if (MRead)  rd_cnt   <= rd_cnt + 1;
    if (MWrite) wr_cnt   <= wr_cnt + 1;
    if (done)   done_cnt <= done_cnt + 1;
  end

  int passed = 0, total = 0;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else passed++;
  endtask

  int stable_bad;
  int rd0, wr0, dn0;

  // Drives one start, then watches until done (bounded); lat = edges after the start edge
  task automatic run_op(input bit ld, input bit st, input logic [N-1:0] mask,
                        input logic [N*AW-1:0] addr, input logic [N*DW-1:0] wd,
                        input bit poke, output int lat);
    @(negedge clk); #1;
    rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt;
    start_load = ld; start_store = st; lane_mask = mask; lane_addr = addr; lane_wdata = wd;
    @(negedge clk);
    start_load = 1'b0; start_store = 1'b0;
    lat = 0;
    stable_bad = 0;
    while (!done && lat < 200) begin
      if (busy && (en !== mask || in_addr !== addr || in_data !== wd)) stable_bad++;
      @(negedge clk);
      lat++;
      start_load = poke && (lat == 2 || lat == 3);
    end
    start_load = 1'b0;
  endtask

  localparam logic [N*AW-1:0] ADDR_A = {16'h0013, 16'h0012, 16'h0011, 16'h0010};
  localparam logic [N*DW-1:0] WD_S   = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

  initial begin
    int lat;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_strobes", {MRead, MWrite, busy, done, timeout_err}, 5'b0);
    check("rst_en", en, '0);
    check("rst_addr_data", {in_addr, in_data}, '0);
    check("rst_load_data", load_data, '0);

    // Load, all lanes, controller low 4 cycles
    q = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
    ctl_k = 4;
    run_op(1'b1, 1'b0, 4'b1111, ADDR_A, '0, 1'b0, lat);
    check("ld_latency", lat, 8);
    check("ld_stable", stable_bad, 0);
    check("ld_load_data", load_data, {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0});
    @(negedge clk); #1;
    check("ld_busy_after_done", busy, 1'b0);
    check("ld_en_cleared", en, '0);
    @(negedge clk); #1;
    check("ld_pulses", {rd_cnt - rd0, wr_cnt - wr0, done_cnt - dn0}, {32'd1, 32'd0, 32'd1});

    // Store, sparse mask
    run_op(1'b0, 1'b1, 4'b0101, ADDR_A, WD_S, 1'b0, lat);
    check("st_latency", lat, 8);
    check("st_stable", stable_bad, 0);
    check("st_timeout_err", timeout_err, 1'b0);
    check("st_load_data_kept", load_data, {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0});
    repeat (2) @(negedge clk); #1;
    check("st_pulses", {rd_cnt - rd0, wr_cnt - wr0, done_cnt - dn0}, {32'd0, 32'd1, 32'd1});

    // Empty mask: straight to FINISH, no strobe
    run_op(1'b1, 1'b0, 4'b0000, ADDR_A, '0, 1'b0, lat);
    check("m0_latency", lat, 1);
    check("m0_load_data_kept", load_data, {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0});
    repeat (2) @(negedge clk); #1;
    check("m0_pulses", {rd_cnt - rd0, wr_cnt - wr0, done_cnt - dn0}, {32'd0, 32'd0, 32'd1});

    // Controller never drops MReady: capture after two WAIT_LOW cycles, masked lanes kept
    ctl_ignore = 1'b1;
    q = {16'h00D3, 16'h00D2, 16'h00D1, 16'h00D0};
    run_op(1'b1, 1'b0, 4'b1010, ADDR_A, '0, 1'b0, lat);
    ctl_ignore = 1'b0;
    check("nd_latency", lat, 5);
    check("nd_load_data", load_data, {16'h00D3, 16'h00A2, 16'h00D1, 16'h00A0});

    // Both starts together, plus a start_load while busy
    ctl_k = 3;
    run_op(1'b1, 1'b1, 4'b1111, ADDR_A, WD_S, 1'b1, lat);
    check("both_latency", lat, 7);
    check("both_stable", stable_bad, 0);
    repeat (4) @(negedge clk); #1;
    check("both_pulses", {rd_cnt - rd0, wr_cnt - wr0, done_cnt - dn0}, {32'd0, 32'd1, 32'd1});
    check("both_idle", busy, 1'b0);

    // Reset while in WAIT_HIGH, then a fresh load
    ctl_k = 10;
    @(negedge clk); #1;
    dn0 = done_cnt;
    start_load = 1'b1; lane_mask = 4'b1111; lane_addr = ADDR_A;
    @(negedge clk);
    start_load = 1'b0;
    repeat (4) @(negedge clk);
    check("rs_busy_before", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("rs_outputs", {MRead, MWrite, en, busy, done}, '0);
    check("rs_load_data", load_data, '0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    check("rs_no_done", done_cnt - dn0, 0);
    ctl_k = 2;
    q = {16'h00B3, 16'h00B2, 16'h00B1, 16'h00B0};
    run_op(1'b1, 1'b0, 4'b0011, ADDR_A, '0, 1'b0, lat);
    check("rs_fresh_latency", lat, 6);
    check("rs_fresh_data", load_data, {16'h0000, 16'h0000, 16'h00B1, 16'h00B0});

    // Controller holds MReady low forever: abort after TIMEOUT wait cycles
    ctl_k = 100000;
    q = {16'h00C3, 16'h00C2, 16'h00C1, 16'h00C0};
    run_op(1'b1, 1'b0, 4'b1111, ADDR_A, '0, 1'b0, lat);
    check("to_latency", lat, TO + 2);
    check("to_err", timeout_err, 1'b1);
    check("to_no_capture", load_data, {16'h0000, 16'h0000, 16'h00B1, 16'h00B0});
    repeat (2) @(negedge clk); #1;
    check("to_done_once", done_cnt - dn0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
